mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the core's single data-memory port between the instruction-fetch path (IFU/icache refill) and the LSU.
- Accepts at most one request at a time and issues it downstream. Routes the response back to the requester that owns it.
- Sits between IFU/LSU and the memory-side bridge. Its grant and stall activity feeds the existing perf-counting infrastructure.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; MASK_W = DATA_W/8
- LSU_FIRST, 1, 1 = fixed priority with LSU winning; 0 = round-robin between IFU and LSU

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU response valid (1-cycle pulse)
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  LSU write data
- lsu_wmask  in  MASK_W  LSU byte strobes
- lsu_resp_valid  out  1  LSU response valid (1-cycle pulse; write ack or read data)
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_addr  out  ADDR_W  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  DATA_W  latched write data
- mem_wmask  out  MASK_W  latched strobes
- mem_resp_valid  in  1  downstream response valid
- mem_rdata  in  DATA_W  downstream read data
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. Registers: state, owner (0 = IFU, 1 = LSU), last_grant, and latched addr/wen/wdata/wmask.
- Reset (reset = 0, asynchronous): state = IDLE, owner = 0, last_grant = IFU, latched fields = 0. All *_ready, *_resp_valid and mem_req_valid are 0; busy = 0.
- IDLE arbitration (combinational): only one of ifu_req_ready / lsu_req_ready may be 1, and only in IDLE, for the winner among the valid requesters.
  - LSU_FIRST = 1: the LSU wins whenever lsu_req_valid = 1.
  - LSU_FIRST = 0: when both are valid, the requester that is not last_grant wins.
  - A sole valid requester always wins.
- Accept (valid & ready): latch the request fields and owner, set last_grant = owner, go to ISSUE. An IFU accept latches wen = 0, wdata = 0, wmask = 0.
- ISSUE:
  - mem_req_valid = 1 and the mem_* fields come from the latches. They stay stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready, go to WAIT.
  - Never drop mem_req_valid before the handshake completes.
- WAIT:
  - Response routing is combinational: ifu_resp_valid = (state == WAIT) & (owner == IFU) & mem_resp_valid; lsu_resp_valid is the same with owner == LSU.
  - ifu_rdata and lsu_rdata are both driven by mem_rdata.
  - On mem_resp_valid, go to IDLE on the next edge.
- Latency:
  - Accept at cycle 0; mem_req_valid from cycle 1.
  - With mem_req_ready = 1 at cycle 1, the response may return from cycle 2 onward.
  - The next accept is possible in the cycle after the response.
- Requesters must hold valid and fields stable until accepted. The arbiter does not sample them after accept.
- mem_resp_valid while in IDLE or ISSUE is ignored: no resp_valid is raised and the state does not change.
- A losing requester keeps waiting. No request is lost or reordered within one requester.
- Reset asserted mid-transaction returns to IDLE immediately and drops the in-flight transaction. Stale responses after reset are ignored by the IDLE rule.

Optional Feature:
- Macro: MEM_BUS_ARBITER_PERF_EN.
- Enabled: adds output ports perf_ifu_grants[31:0], perf_lsu_grants[31:0], perf_stall_cycles[31:0] and perf_stray_resp[0:0].
  - The grant counters increment on each accept.
  - perf_stall_cycles increments every cycle in which some req_valid = 1 but its req_ready = 0.
  - All counters saturate at 0xFFFFFFFF.
  - perf_stray_resp is a sticky flag set by mem_resp_valid outside WAIT.
  - All are cleared by reset.
- Disabled: these ports and counters are absent. Functional behaviour is otherwise identical.

Test Plan:
- Single IFU read: ifu_req_valid, addr 0x80000000, mem_req_ready = 1 and mem_resp_valid with rdata 0x00100073 two cycles later -> mem_addr = 0x80000000, mem_wen = 0, one ifu_resp_valid pulse carrying 0x00100073, lsu_resp_valid = 0.
- Simultaneous requests, LSU_FIRST = 1: IFU read 0x80000004 and LSU write 0xA0000000 / 0xDEADBEEF / mask 0xF -> LSU issued first with mem_wen = 1 and mem_wdata = 0xDEADBEEF. The IFU is issued only after the LSU response.
- Round-robin (LSU_FIRST = 0): both requesters held valid for 4 transactions -> grant order IFU, LSU, IFU, LSU.
- Downstream backpressure: mem_req_ready = 0 for 5 cycles -> mem_req_valid stays 1 with constant fields and no accept occurs. The handshake completes on the 6th cycle.
- Stray response: mem_resp_valid pulsed in IDLE -> no resp_valid and state stays IDLE. With MEM_BUS_ARBITER_PERF_EN, perf_stray_resp = 1.
- Reset mid-WAIT: reset = 0 for 1 cycle -> busy = 0 and all valid/ready outputs 0. A later mem_resp_valid produces no resp_valid, and the next request is accepted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between IFU and LSU; a single request is in flight at a time and its response goes back to its owner.
// Optional perf counters are enabled with `define MEM_BUS_ARBITER_PERF_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LSU_FIRST = 1,
  localparam int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_BUS_ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_ifu_grants,
  output logic [31:0]       perf_lsu_grants,
  output logic [31:0]       perf_stall_cycles,
  output logic [0:0]        perf_stray_resp
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]        state;
  logic              owner;
  logic              last_grant;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_wen;
  logic [DATA_W-1:0] lat_wdata;
  logic [MASK_W-1:0] lat_wmask;

  logic idle;
  logic grant_lsu;
  logic grant_ifu;
  logic ifu_acc;
  logic lsu_acc;
  logic accept;
  logic in_wait;

  // Ready is also held low while reset is asserted, not just after the first edge.
  assign idle = (state == ST_IDLE) && reset;

  always_comb begin
    grant_lsu = 1'b0;
    if (lsu_req_valid) begin
      if (LSU_FIRST != 0) begin
        grant_lsu = 1'b1;
      end else begin
        grant_lsu = !ifu_req_valid || (last_grant == OWN_IFU);
      end
    end
  end

  assign grant_ifu     = ifu_req_valid && !grant_lsu;
  assign ifu_req_ready = idle && grant_ifu;
  assign lsu_req_ready = idle && grant_lsu;
  assign ifu_acc       = ifu_req_valid && ifu_req_ready;
  assign lsu_acc       = lsu_req_valid && lsu_req_ready;
  assign accept        = ifu_acc || lsu_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept)         state <= ST_ISSUE;
        ST_ISSUE: if (mem_req_ready)  state <= ST_WAIT;
        ST_WAIT:  if (mem_resp_valid) state <= ST_IDLE;
        default:                      state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= OWN_IFU;
      last_grant <= OWN_IFU;
      lat_addr   <= '0;
      lat_wen    <= 1'b0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
    end else if (lsu_acc) begin
      owner      <= OWN_LSU;
      last_grant <= OWN_LSU;
      lat_addr   <= lsu_addr;
      lat_wen    <= lsu_wen;
      lat_wdata  <= lsu_wdata;
      lat_wmask  <= lsu_wmask;
    end else if (ifu_acc) begin
      owner      <= OWN_IFU;
      last_grant <= OWN_IFU;
      lat_addr   <= ifu_addr;
      lat_wen    <= 1'b0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
    end
  end

  assign mem_req_valid = (state == ST_ISSUE);
  assign mem_addr      = lat_addr;
  assign mem_wen       = lat_wen;
  assign mem_wdata     = lat_wdata;
  assign mem_wmask     = lat_wmask;

  // Responses outside WAIT are strays and never reach a requester.
  assign in_wait        = (state == ST_WAIT);
  assign ifu_resp_valid = in_wait && (owner == OWN_IFU) && mem_resp_valid;
  assign lsu_resp_valid = in_wait && (owner == OWN_LSU) && mem_resp_valid;
  assign ifu_rdata      = mem_rdata;
  assign lsu_rdata      = mem_rdata;

  assign busy = (state != ST_IDLE);

`ifdef MEM_BUS_ARBITER_PERF_EN
  logic stall;
  assign stall = (ifu_req_valid && !ifu_req_ready) || (lsu_req_valid && !lsu_req_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_ifu_grants   <= '0;
      perf_lsu_grants   <= '0;
      perf_stall_cycles <= '0;
      perf_stray_resp   <= 1'b0;
    end else begin
      if (ifu_acc && (perf_ifu_grants != 32'hFFFF_FFFF)) begin
        perf_ifu_grants <= perf_ifu_grants + 32'd1;
      end
      if (lsu_acc && (perf_lsu_grants != 32'hFFFF_FFFF)) begin
        perf_lsu_grants <= perf_lsu_grants + 32'd1;
      end
      if (stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (mem_resp_valid && !in_wait) begin
        perf_stray_resp <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a random run against a transaction-level model,
// and a second round-robin instance for grant ordering.
module tb_mem_bus_arbiter;

  localparam int LSU_FIRST_MAIN = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  logic        rr_ifu_req_valid, rr_ifu_req_ready, rr_ifu_resp_valid;
  logic [31:0] rr_ifu_rdata;
  logic        rr_lsu_req_valid, rr_lsu_req_ready, rr_lsu_resp_valid;
  logic [31:0] rr_lsu_rdata;
  logic        rr_mem_req_valid, rr_mem_req_ready, rr_mem_wen, rr_mem_resp_valid, rr_busy;
  logic [31:0] rr_mem_addr, rr_mem_wdata;
  logic [3:0]  rr_mem_wmask;

`ifdef MEM_BUS_ARBITER_PERF_EN
  logic [31:0] perf_ifu_grants, perf_lsu_grants, perf_stall_cycles;
  logic [0:0]  perf_stray_resp;
  logic [31:0] rr_perf_ifu_grants, rr_perf_lsu_grants, rr_perf_stall_cycles;
  logic [0:0]  rr_perf_stray_resp;
`endif

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_FIRST(LSU_FIRST_MAIN)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_BUS_ARBITER_PERF_EN
    , .perf_ifu_grants(perf_ifu_grants), .perf_lsu_grants(perf_lsu_grants),
    .perf_stall_cycles(perf_stall_cycles), .perf_stray_resp(perf_stray_resp)
`endif
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_FIRST(0)) dut_rr (
    .clk(clk), .reset(reset),
    .ifu_req_valid(rr_ifu_req_valid), .ifu_req_ready(rr_ifu_req_ready), .ifu_addr(32'h0000_1000),
    .ifu_resp_valid(rr_ifu_resp_valid), .ifu_rdata(rr_ifu_rdata),
    .lsu_req_valid(rr_lsu_req_valid), .lsu_req_ready(rr_lsu_req_ready), .lsu_addr(32'h0000_2000),
    .lsu_wen(1'b0), .lsu_wdata(32'h0), .lsu_wmask(4'h0),
    .lsu_resp_valid(rr_lsu_resp_valid), .lsu_rdata(rr_lsu_rdata),
    .mem_req_valid(rr_mem_req_valid), .mem_req_ready(rr_mem_req_ready), .mem_addr(rr_mem_addr),
    .mem_wen(rr_mem_wen), .mem_wdata(rr_mem_wdata), .mem_wmask(rr_mem_wmask),
    .mem_resp_valid(rr_mem_resp_valid), .mem_rdata(32'h1234_5678), .busy(rr_busy)
`ifdef MEM_BUS_ARBITER_PERF_EN
    , .perf_ifu_grants(rr_perf_ifu_grants), .perf_lsu_grants(rr_perf_lsu_grants),
    .perf_stall_cycles(rr_perf_stall_cycles), .perf_stray_resp(rr_perf_stray_resp)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: phase 0 = free, 1 = request offered downstream, 2 = awaiting response.
  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        lsu;
  } tx_t;

  tx_t tx;
  int  phase = 0;
  bit  last_lsu = 1'b0;
  int  n_acc_ifu = 0, n_acc_lsu = 0, n_resp_ifu = 0, n_resp_lsu = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic iv, input logic lv);
    if (lv && (!iv || LSU_FIRST_MAIN != 0 || !last_lsu)) return 2;
    if (iv) return 1;
    return 0;
  endfunction

  task automatic cycle();
    int w;
    bit acc_i, acc_l;
    #1;
    w = (phase == 0) ? winner(ifu_req_valid, lsu_req_valid) : 0;
    chk("ifu_req_ready", ifu_req_ready, w == 1);
    chk("lsu_req_ready", lsu_req_ready, w == 2);
    chk("busy", busy, phase != 0);
    chk("mem_req_valid", mem_req_valid, phase == 1);
    if (phase == 1) begin
      chk("mem_addr", mem_addr, tx.addr);
      chk("mem_wen", mem_wen, tx.wen);
      chk("mem_wdata", mem_wdata, tx.wdata);
      chk("mem_wmask", mem_wmask, tx.wmask);
    end
    chk("ifu_resp_valid", ifu_resp_valid, phase == 2 && mem_resp_valid && !tx.lsu);
    chk("lsu_resp_valid", lsu_resp_valid, phase == 2 && mem_resp_valid && tx.lsu);
    if (phase == 2 && mem_resp_valid) begin
      if (tx.lsu) chk("lsu_rdata", lsu_rdata, mem_rdata);
      else        chk("ifu_rdata", ifu_rdata, mem_rdata);
    end
    if (ifu_resp_valid === 1'b1) n_resp_ifu++;
    if (lsu_resp_valid === 1'b1) n_resp_lsu++;
    acc_i = (w == 1);
    acc_l = (w == 2);
    if (acc_l) begin
      tx = '{lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, 1'b1};
      phase = 1; last_lsu = 1'b1; n_acc_lsu++;
    end else if (acc_i) begin
      tx = '{ifu_addr, 1'b0, 32'h0, 4'h0, 1'b0};
      phase = 1; last_lsu = 1'b0; n_acc_ifu++;
    end else if (phase == 1 && mem_req_ready) begin
      phase = 2;
    end else if (phase == 2 && mem_resp_valid) begin
      phase = 0;
    end
    @(negedge clk);
    if (acc_i) ifu_req_valid = 1'b0;
    if (acc_l) lsu_req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    reset = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h0;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    rr_ifu_req_valid = 1'b0; rr_lsu_req_valid = 1'b0; rr_mem_req_ready = 1'b0; rr_mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ifu_ready", ifu_req_ready, 0);
    chk("rst_lsu_ready", lsu_req_ready, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_ifu_resp", ifu_resp_valid, 0);
    chk("rst_lsu_resp", lsu_resp_valid, 0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Single IFU read.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
    cycle();
    cycle();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0073;
    cycle();
    mem_resp_valid = 1'b0;
    cycle();
    chk("single_ifu_resp_count", n_resp_ifu, 1);

    // Simultaneous requests: LSU write goes first.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'hA000_0000; lsu_wen = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    cycle();
    #1;
    chk("simul_mem_wen", mem_wen, 1);
    chk("simul_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cycle();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0;
    cycle();
    mem_resp_valid = 1'b0;
    cycle();
    cycle();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0013;
    cycle();
    mem_resp_valid = 1'b0;
    chk("simul_lsu_resp_count", n_resp_lsu, 1);
    chk("simul_ifu_resp_count", n_resp_ifu, 2);

    // Downstream backpressure for 5 cycles.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    cycle();
    mem_req_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_addr = 32'hA000_0040; lsu_wen = 1'b0;
    repeat (5) cycle();
    mem_req_ready = 1'b1;
    cycle();
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0001;
    cycle();
    mem_resp_valid = 1'b0;
    cycle();
    cycle();
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0002;
    cycle();
    mem_resp_valid = 1'b0;

    // Stray response in IDLE.
    mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    cycle();
    mem_resp_valid = 1'b0;
    cycle();
`ifdef MEM_BUS_ARBITER_PERF_EN
    chk("perf_stray_resp", perf_stray_resp, 1);
`endif

    // Reset in the middle of WAIT.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    cycle();
    cycle();
    lsu_req_valid = 1'b1; lsu_addr = 32'hA000_0080; lsu_wen = 1'b1; lsu_wdata = 32'h5555_AAAA; lsu_wmask = 4'h3;
    reset = 1'b0; mem_resp_valid = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ifu_ready", ifu_req_ready, 0);
    chk("midrst_lsu_ready", lsu_req_ready, 0);
    chk("midrst_mem_req_valid", mem_req_valid, 0);
    chk("midrst_ifu_resp", ifu_resp_valid, 0);
    chk("midrst_lsu_resp", lsu_resp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    phase = 0; last_lsu = 1'b0;
    n_acc_ifu = 0; n_acc_lsu = 0; n_resp_ifu = 0; n_resp_lsu = 0;
    lsu_req_valid = 1'b0;
    cycle();
    mem_resp_valid = 1'b0;
    lsu_req_valid = 1'b1;
    cycle();
    cycle();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0;
    cycle();
    mem_resp_valid = 1'b0;
    chk("postrst_lsu_resp_count", n_resp_lsu, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (!ifu_req_valid && $urandom_range(0, 3) == 0) begin
        ifu_req_valid = 1'b1; ifu_addr = $urandom;
      end
      if (!lsu_req_valid && $urandom_range(0, 3) == 0) begin
        lsu_req_valid = 1'b1; lsu_addr = $urandom; lsu_wen = 1'($urandom_range(0, 1));
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom_range(0, 15));
      end
      mem_req_ready = ($urandom_range(0, 2) != 0);
      mem_resp_valid = (phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      cycle();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    for (int i = 0; i < 10 && phase != 0; i++) begin
      mem_resp_valid = (phase == 2); mem_rdata = $urandom;
      cycle();
    end
    mem_resp_valid = 1'b0;
    chk("drain_idle", phase, 0);
    chk("ifu_no_loss", n_resp_ifu, n_acc_ifu);
    chk("lsu_no_loss", n_resp_lsu, n_acc_lsu);
`ifdef MEM_BUS_ARBITER_PERF_EN
    chk("perf_ifu_grants", perf_ifu_grants, n_acc_ifu);
    chk("perf_lsu_grants", perf_lsu_grants, n_acc_lsu);
`endif

    // Round-robin instance: an LSU-only grant first, then both held valid.
    rr_mem_req_ready = 1'b1; rr_mem_resp_valid = 1'b1; rr_lsu_req_valid = 1'b1;
    #1;
    chk("rr_first_lsu_ready", rr_lsu_req_ready, 1);
    @(negedge clk);
    rr_ifu_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = -1;
      for (int c = 0; c < 8 && got < 0; c++) begin
        #1;
        if (rr_ifu_req_ready || rr_lsu_req_ready) begin
          chk("rr_single_ready", rr_ifu_req_ready && rr_lsu_req_ready, 0);
          got = rr_lsu_req_ready ? 1 : 0;
        end
        @(negedge clk);
      end
      chk("rr_order", got, k % 2);
    end
    rr_ifu_req_valid = 1'b0; rr_lsu_req_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
